// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher
// During horizontal blanking, walks three sprite descriptors (2, 1, 0).
// For each sprite that covers the next scanline, it reads one 32-pixel row
// from the ROM selected by the sprite id and composites it into a 640-entry
// line buffer.
// During active video the buffer is streamed out as per-pixel RGB and
// cleared on read.
// Optional build macro SPRITE_HFLIP_EN: descriptor bit 25 mirrors the
// sprite horizontally.
module sprite_line_fetcher #(
  parameter int          H_ACTIVE    = 640,
  parameter int          V_TOTAL     = 525,
  parameter int          SPR_SIZE    = 32,
  parameter logic [23:0] TRANSPARENT = 24'h000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [31:0] sprite0,
  input  logic [31:0] sprite1,
  input  logic [31:0] sprite2,
  output logic [9:0]  rom_addr,
  output logic [4:0]  rom_id,
  input  logic [23:0] rom_q,
  output logic [23:0] pix_rgb,
  output logic        pix_opaque,
  output logic        fetch_busy
);

  localparam int SPR_BITS = $clog2(SPR_SIZE);
`ifdef SPRITE_HFLIP_EN
  localparam int DESC_W = 26;
`else
  localparam int DESC_W = 25;
`endif
  localparam logic [9:0]          H_ACT10  = 10'(H_ACTIVE);
  localparam logic [9:0]          H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]          V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]          SPR_LIM  = 10'(SPR_SIZE);
  localparam logic [SPR_BITS-1:0] COL_LAST = SPR_BITS'(SPR_SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4
  } state_t;

  state_t              state_r;
  logic [1:0]          sel_r;
  logic [DESC_W-1:0]   snap0_r, snap1_r, snap2_r;
  logic [9:0]          line_r;
  logic [SPR_BITS-1:0] row_r;
  logic [SPR_BITS-1:0] col_r;
  logic [4:0]          cur_id_r;
  logic [9:0]          cur_x_r;
`ifdef SPRITE_HFLIP_EN
  logic                cur_flip_r;
`endif
  logic [9:0]          rom_addr_r;
  logic [4:0]          rom_id_r;
  logic                fetch_busy_r;

  // Write pipeline: issue stage aligned with rom_addr, data stage aligned with rom_q
  logic                iss_v_r;
  logic [10:0]         iss_addr_r;
  logic                dat_v_r;
  logic [10:0]         dat_addr_r;

  // Readout pipeline
  logic                primed_r;
  logic                rd_v_r;
  logic                clr_v_r;
  logic [9:0]          clr_addr_r;
  logic [23:0]         rd_data_r;
  logic [23:0]         pix_rgb_r;
  logic                pix_opaque_r;

  logic [23:0]         line_buf [0:H_ACTIVE-1];

  logic [DESC_W-1:0]   desc_s;
  logic [9:0]          row_full_s;
  logic                id_ok_s;
  logic                hit_s;
  logic [SPR_BITS-1:0] fetch_col_s;
  logic [9:0]          next_line_s;
  logic                wr_en_s;
  logic                unused_bits_s;

`ifdef SPRITE_HFLIP_EN
  assign unused_bits_s = ^{sprite0[31:26], sprite1[31:26], sprite2[31:26]};
`else
  assign unused_bits_s = ^{sprite0[31:25], sprite1[31:25], sprite2[31:25]};
`endif

  // Select the descriptor under evaluation and decide whether it covers the target line
  always_comb begin
    desc_s = snap0_r;
    case (sel_r)
      2'd0:    desc_s = snap0_r;
      2'd1:    desc_s = snap1_r;
      2'd2:    desc_s = snap2_r;
      default: desc_s = snap0_r;
    endcase
    row_full_s = line_r - desc_s[9:0];
    case (desc_s[24:20])
      5'd0, 5'd2, 5'd3: id_ok_s = 1'b1;
      default:          id_ok_s = 1'b0;
    endcase
    if ((row_full_s < SPR_LIM) && id_ok_s) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // ROM column: mirrored when the sprite is flagged for horizontal flip
  always_comb begin
`ifdef SPRITE_HFLIP_EN
    if (cur_flip_r) begin
      fetch_col_s = ~col_r;
    end else begin
      fetch_col_s = col_r;
    end
`else
    fetch_col_s = col_r;
`endif
  end

  // Next scanline to fetch, wrapping at the bottom of the frame
  always_comb begin
    if (vcount == V_LAST) begin
      next_line_s = 10'd0;
    end else begin
      next_line_s = vcount + 10'd1;
    end
  end

  // Buffer write qualifier: opaque ROM data landing inside the visible line
  always_comb begin
    if (dat_v_r && (rom_q != TRANSPARENT) && (dat_addr_r < {1'b0, H_ACT10})) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Fetch sequencer: snapshot descriptors, then walk sprites 2..0 issuing ROM reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      sel_r        <= 2'd0;
      snap0_r      <= '0;
      snap1_r      <= '0;
      snap2_r      <= '0;
      line_r       <= 10'd0;
      row_r        <= '0;
      col_r        <= '0;
      cur_id_r     <= 5'd0;
      cur_x_r      <= 10'd0;
`ifdef SPRITE_HFLIP_EN
      cur_flip_r   <= 1'b0;
`endif
      rom_addr_r   <= 10'd0;
      rom_id_r     <= 5'd0;
      fetch_busy_r <= 1'b0;
      iss_v_r      <= 1'b0;
      iss_addr_r   <= 11'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          iss_v_r <= 1'b0;
          if (hcount == H_ACT10) begin
            snap0_r      <= sprite0[DESC_W-1:0];
            snap1_r      <= sprite1[DESC_W-1:0];
            snap2_r      <= sprite2[DESC_W-1:0];
            line_r       <= next_line_s;
            sel_r        <= 2'd2;
            state_r      <= ST_SETUP;
            fetch_busy_r <= 1'b1;
          end else begin
            fetch_busy_r <= 1'b0;
          end
        end
        ST_SETUP: begin
          iss_v_r <= 1'b0;
          if (hit_s) begin
            row_r    <= row_full_s[SPR_BITS-1:0];
            cur_id_r <= desc_s[24:20];
            cur_x_r  <= desc_s[19:10];
`ifdef SPRITE_HFLIP_EN
            cur_flip_r <= desc_s[25];
`endif
            col_r    <= '0;
            state_r  <= ST_FETCH;
          end else begin
            state_r <= ST_NEXT;
          end
        end
        ST_FETCH: begin
          rom_addr_r <= {row_r, fetch_col_s};
          rom_id_r   <= cur_id_r;
          iss_v_r    <= 1'b1;
          iss_addr_r <= {1'b0, cur_x_r} + 11'(col_r);
          col_r      <= col_r + SPR_BITS'(1);
          if (col_r == COL_LAST) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          iss_v_r <= 1'b0;
          state_r <= ST_NEXT;
        end
        ST_NEXT: begin
          iss_v_r <= 1'b0;
          if (sel_r == 2'd0) begin
            state_r      <= ST_IDLE;
            fetch_busy_r <= 1'b0;
          end else begin
            sel_r   <= sel_r - 2'd1;
            state_r <= ST_SETUP;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          fetch_busy_r <= 1'b0;
          iss_v_r      <= 1'b0;
        end
      endcase
    end
  end

  // Delay the write target by one clock so it lines up with rom_q
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dat_v_r    <= 1'b0;
      dat_addr_r <= 11'd0;
    end else begin
      dat_v_r    <= iss_v_r;
      dat_addr_r <= iss_addr_r;
    end
  end

  // Readout control: priming, read qualifier, clear-on-read target, registered pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primed_r     <= 1'b0;
      rd_v_r       <= 1'b0;
      clr_v_r      <= 1'b0;
      clr_addr_r   <= 10'd0;
      pix_rgb_r    <= 24'h000000;
      pix_opaque_r <= 1'b0;
    end else begin
      if (hcount == H_LAST) begin
        primed_r <= 1'b1;
      end
      rd_v_r       <= (hcount < H_ACT10) && primed_r;
      clr_v_r      <= (hcount < H_ACT10);
      clr_addr_r   <= hcount;
      pix_rgb_r    <= rd_v_r ? rd_data_r : 24'h000000;
      pix_opaque_r <= rd_v_r && (rd_data_r != TRANSPARENT);
    end
  end

  // Line buffer: one write port shared by clear-on-read and sprite writes, one read port
  always_ff @(posedge clk) begin
    if (clr_v_r) begin
      line_buf[clr_addr_r] <= TRANSPARENT;
    end else if (wr_en_s) begin
      line_buf[dat_addr_r[9:0]] <= rom_q;
    end
    if (hcount < H_ACT10) begin
      rd_data_r <= line_buf[hcount];
    end else begin
      rd_data_r <= TRANSPARENT;
    end
  end

  assign rom_addr   = rom_addr_r;
  assign rom_id     = rom_id_r;
  assign pix_rgb    = pix_rgb_r;
  assign pix_opaque = pix_opaque_r;
  assign fetch_busy = fetch_busy_r;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher: drives whole scanlines and checks
// the streamed pixels against hand-built expected lines.
// It also checks fetch_busy durations, reset behaviour and ROM activity.
module tb_sprite_line_fetcher;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [31:0] sprite0, sprite1, sprite2;
  logic [9:0]  rom_addr;
  logic [4:0]  rom_id;
  logic [23:0] rom_q = 24'h000000;
  logic [23:0] pix_rgb;
  logic        pix_opaque;
  logic        fetch_busy;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_rgb [0:639];
  int busy_cnt;
  int rom_chg;

  sprite_line_fetcher dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hcount    (hcount),
    .vcount    (vcount),
    .sprite0   (sprite0),
    .sprite1   (sprite1),
    .sprite2   (sprite2),
    .rom_addr  (rom_addr),
    .rom_id    (rom_id),
    .rom_q     (rom_q),
    .pix_rgb   (pix_rgb),
    .pix_opaque(pix_opaque),
    .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  // ship(0): addr+1; pig(2): odd columns transparent; bee(3): always opaque
  function automatic logic [23:0] rom_model(input logic [4:0] id, input logic [9:0] a);
    case (id)
      5'd0:    return 24'(a) + 24'd1;
      5'd2:    return a[0] ? 24'h000000 : (24'hA00000 | 24'(a));
      5'd3:    return 24'hB00000 | 24'(a);
      default: return 24'hDEAD01;
    endcase
  endfunction

  // Synchronous ROM: data one clock after the address
  always @(posedge clk) rom_q <= rom_model(rom_id, rom_addr);

  function automatic logic [31:0] desc(input logic flip, input logic [4:0] id,
                                       input logic [9:0] x, input logic [9:0] y);
    return {6'd0, flip, id, x, y};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_zero();
    for (int i = 0; i < 640; i++) exp_rgb[i] = 24'h000000;
  endtask

  // One full scanline; output seen after the edge for step k belongs to hcount k-1
  task automatic run_line(input logic [9:0] v, input int rst_at, input int rst_rel,
                          input int chg_at, input logic [31:0] chg_val,
                          output int busy, output int rchg);
    logic [9:0]  pa;
    logic [4:0]  pi;
    logic [23:0] e;
    busy = 0;
    rchg = 0;
    pa = rom_addr;
    pi = rom_id;
    for (int k = 0; k < 800; k++) begin
      hcount = 10'(k);
      vcount = v;
      if (k == rst_at)  reset_n = 1'b0;
      if (k == rst_rel) reset_n = 1'b1;
      if (k == chg_at)  sprite0 = chg_val;
      @(posedge clk);
      #1;
      if (fetch_busy) busy++;
      if ((rom_addr !== pa) || (rom_id !== pi)) rchg++;
      pa = rom_addr;
      pi = rom_id;
      if (k >= 1) begin
        if (k - 1 < 640) e = exp_rgb[k-1];
        else             e = 24'h000000;
        chk($sformatf("rgb_v%0d_h%0d", v, k - 1), {8'h00, pix_rgb}, {8'h00, e});
        chk($sformatf("opq_v%0d_h%0d", v, k - 1), {31'd0, pix_opaque}, {31'd0, (e != 24'h000000)});
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    hcount  = 10'd0;
    vcount  = 10'd0;
    sprite0 = desc(1'b0, 5'd1, 10'd0, 10'd0);
    sprite1 = desc(1'b0, 5'd1, 10'd0, 10'd0);
    sprite2 = desc(1'b0, 5'd1, 10'd0, 10'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
    chk("rst_rom_id",   {27'd0, rom_id},   32'd0);
    chk("rst_pix_rgb",  {8'd0, pix_rgb},   32'd0);
    chk("rst_opaque",   {31'd0, pix_opaque}, 32'd0);
    chk("rst_busy",     {31'd0, fetch_busy}, 32'd0);
    reset_n = 1'b1;

    // Line 49: output still gated; fetch ship row 0 for line 50
    sprite0 = desc(1'b0, 5'd0, 10'd100, 10'd50);
    exp_zero();
    run_line(10'd49, -1, -1, -1, 32'd0, busy_cnt, rom_chg);
    chk("busy_one_sprite_a", busy_cnt, 39);

    // Line 50: ship row 0 at 100..131; descriptor moved after the snapshot
    exp_zero();
    for (int c = 0; c < 32; c++) exp_rgb[100+c] = 24'(c + 1);
    run_line(10'd50, -1, -1, 645, desc(1'b0, 5'd0, 10'd300, 10'd50), busy_cnt, rom_chg);
    chk("busy_one_sprite_b", busy_cnt, 39);

    // Snapshot held: row 1 still at x=100; fetch pig over bee for line 11
    sprite0 = desc(1'b0, 5'd2, 10'd200, 10'd10);
    sprite1 = desc(1'b0, 5'd3, 10'd200, 10'd10);
    sprite2 = desc(1'b0, 5'd1, 10'd0, 10'd0);
    exp_zero();
    for (int c = 0; c < 32; c++) exp_rgb[100+c] = 24'(c + 33);
    run_line(10'd10, -1, -1, -1, 32'd0, busy_cnt, rom_chg);
    chk("busy_two_sprites", busy_cnt, 72);

    // Pig on even columns, bee shows through odd ones; fetch right-edge sprite at wrap
    sprite0 = desc(1'b0, 5'd1, 10'd0, 10'd0);
    sprite1 = desc(1'b0, 5'd1, 10'd0, 10'd0);
    sprite2 = desc(1'b0, 5'd0, 10'd620, 10'd0);
    exp_zero();
    for (int c = 0; c < 32; c++)
      exp_rgb[200+c] = ((c % 2) == 0) ? (24'hA00000 | 24'(32 + c)) : (24'hB00000 | 24'(32 + c));
    run_line(10'd524, -1, -1, -1, 32'd0, busy_cnt, rom_chg);
    chk("busy_edge_sprite", busy_cnt, 39);

    // Clipped sprite: columns 0..19 at 620..639, nothing at 0..11; all ids invalid next
    sprite2 = desc(1'b0, 5'd1, 10'd0, 10'd0);
    exp_zero();
    for (int c = 0; c < 20; c++) exp_rgb[620+c] = 24'(c + 1);
    run_line(10'd0, -1, -1, -1, 32'd0, busy_cnt, rom_chg);
    chk("busy_invalid_ids", busy_cnt, 6);
    chk("rom_idle_invalid", rom_chg, 0);

    // Blank line, then reset in the middle of a fetch
    sprite0 = desc(1'b0, 5'd0, 10'd100, 10'd50);
    exp_zero();
    run_line(10'd49, 660, 700, -1, 32'd0, busy_cnt, rom_chg);
    chk("busy_until_reset", busy_cnt, 20);
    chk("post_rst_rom_addr", {22'd0, rom_addr}, 32'd0);
    chk("post_rst_rom_id",   {27'd0, rom_id},   32'd0);

    // Unprimed line: gated output; fetch row 1 for the following line
    exp_zero();
    run_line(10'd50, -1, -1, -1, 32'd0, busy_cnt, rom_chg);
    chk("busy_after_reset", busy_cnt, 39);

    // Clean render after reset; queue a flagged sprite at x=0
    sprite0 = desc(1'b1, 5'd0, 10'd0, 10'd100);
    exp_zero();
    for (int c = 0; c < 32; c++) exp_rgb[100+c] = 24'(c + 33);
    run_line(10'd99, -1, -1, -1, 32'd0, busy_cnt, rom_chg);
    chk("busy_flip_fetch", busy_cnt, 39);

    // Mirror flag honoured only when the feature is built in
    sprite0 = desc(1'b0, 5'd1, 10'd0, 10'd0);
    exp_zero();
`ifdef SPRITE_HFLIP_EN
    for (int c = 0; c < 32; c++) exp_rgb[c] = 24'(32 - c);
`else
    for (int c = 0; c < 32; c++) exp_rgb[c] = 24'(c + 1);
`endif
    run_line(10'd100, -1, -1, -1, 32'd0, busy_cnt, rom_chg);
    chk("busy_final", busy_cnt, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
